fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode-side instruction output.
// Latency: none, wires only.
// Backpressure: id_ready from decode; imem_ack completes the single outstanding memory request.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_ack, imem_rdata, redirect, redirect_target, id_ready
  );

  // Environment side: memory, execute stage and decode
  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_ack, imem_rdata, redirect, redirect_target, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding memory requests, 2-entry {instr, pc} FIFO to decode.
// Latency: instr_valid rises the cycle after the ack edge; one instruction per cycle with same-cycle acks.
// Backpressure: id_ready=0 fills the FIFO and parks the FSM in STALL (no request) until decode dequeues.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;      // next address to fetch; in DRAIN this is the pending redirect target
  logic [31:0] r_addr;    // address of the request on the bus; held in DRAIN for the old request
  logic        r_req;

  // FIFO storage, slot 0 is always the head
  logic [31:0] r_dat [2];
  logic [31:0] r_fpc [2];
  logic [1:0]  r_cnt;
  logic        r_valid;

  logic        w_deq;
  logic        w_enq;
  logic        w_flush;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;
  logic [31:0] w_dat_nxt [2];
  logic [31:0] w_fpc_nxt [2];
  logic [1:0]  w_cnt_nxt;

  assign w_tgt    = bus.redirect_target & ~32'h3;
  assign w_pc_inc = r_pc + 32'd4;
  assign w_deq    = (r_cnt != 2'd0) && bus.id_ready;
  // An ack only carries a usable word in FETCH, and never alongside a redirect
  assign w_enq    = (r_state == S_FETCH) && bus.imem_ack && !bus.redirect;
  assign w_flush  = bus.redirect;

  // Next FIFO contents: dequeue shifts slot 1 forward, enqueue lands behind whatever remains
  always_comb begin
    w_dat_nxt[0] = r_dat[0];
    w_dat_nxt[1] = r_dat[1];
    w_fpc_nxt[0] = r_fpc[0];
    w_fpc_nxt[1] = r_fpc[1];
    w_cnt_nxt    = r_cnt;
    if (w_flush) begin
      w_dat_nxt[0] = 32'h0;
      w_dat_nxt[1] = 32'h0;
      w_fpc_nxt[0] = 32'h0;
      w_fpc_nxt[1] = 32'h0;
      w_cnt_nxt    = 2'd0;
    end else begin
      if (w_deq) begin
        w_dat_nxt[0] = r_dat[1];
        w_fpc_nxt[0] = r_fpc[1];
        w_dat_nxt[1] = 32'h0;
        w_fpc_nxt[1] = 32'h0;
        w_cnt_nxt    = r_cnt - 2'd1;
      end
      if (w_enq) begin
        if (w_cnt_nxt == 2'd0) begin
          w_dat_nxt[0] = bus.imem_rdata;
          w_fpc_nxt[0] = r_pc;
        end else begin
          w_dat_nxt[1] = bus.imem_rdata;
          w_fpc_nxt[1] = r_pc;
        end
        w_cnt_nxt = w_cnt_nxt + 2'd1;
      end
    end
  end

  // FIFO registers and the registered valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat[0] <= 32'h0;
      r_dat[1] <= 32'h0;
      r_fpc[0] <= 32'h0;
      r_fpc[1] <= 32'h0;
      r_cnt    <= 2'd0;
      r_valid  <= 1'b0;
    end else begin
      r_dat[0] <= w_dat_nxt[0];
      r_dat[1] <= w_dat_nxt[1];
      r_fpc[0] <= w_fpc_nxt[0];
      r_fpc[1] <= w_fpc_nxt[1];
      r_cnt    <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != 2'd0);
    end
  end

  // Fetch FSM with registered request/address; a redirect overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else if (bus.redirect) begin
      r_pc  <= w_tgt;
      r_req <= 1'b1;
      if ((r_state == S_FETCH || r_state == S_DRAIN) && !bus.imem_ack) begin
        // Old request still in flight: keep showing its address until its ack retires it
        r_state <= S_DRAIN;
      end else begin
        r_state <= S_FETCH;
        r_addr  <= w_tgt;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_pc   <= w_pc_inc;
            r_addr <= w_pc_inc;
            if (w_cnt_nxt == 2'd2) begin
              r_state <= S_STALL;
              r_req   <= 1'b0;
            end
          end
        end
        S_STALL: begin
          if (w_deq) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        S_DRAIN: begin
          if (bus.imem_ack) begin
            r_state <= S_FETCH;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = r_valid;
  assign bus.instruction = r_dat[0];
  assign bus.instr_pc    = r_fpc[0];

endmodule
